// File: rtl/mips_decode_stage_if.sv
// Handshake and decoded-result bundle for the MIPS decode stage.
// The producer/consumer side (fetch + register read) uses master and the
// decode stage uses slave.
interface mips_decode_stage_if #(
  parameter int IMM_W = 32,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             out_valid;
  logic             out_ready;
  logic             rtype;
  logic             itype;
  logic             jtype;
  logic             illegal;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [5:0]       funct;
  logic [5:0]       opcode;
  logic [IMM_W-1:0] imm_ext;
  logic [25:0]      jidx;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_i;
  logic [CNT_W-1:0] cnt_j;
  logic [CNT_W-1:0] cnt_ill;

  modport master (
    output flush, in_valid, instr, out_ready,
    input  in_ready, out_valid, rtype, itype, jtype, illegal,
    input  rs, rt, rd, shamt, funct, opcode, imm_ext, jidx,
    input  cnt_r, cnt_i, cnt_j, cnt_ill
  );

  modport slave (
    input  flush, in_valid, instr, out_ready,
    output in_ready, out_valid, rtype, itype, jtype, illegal,
    output rs, rt, rd, shamt, funct, opcode, imm_ext, jidx,
    output cnt_r, cnt_i, cnt_j, cnt_ill
  );
endinterface

// File: rtl/mips_decode_stage.sv
// Registered, valid/ready flow-controlled MIPS instruction decode stage.
// One-deep output register, explicit J-type recognition, illegal-opcode
// flagging and saturating per-class accept counters.
module mips_decode_stage #(
  parameter int IMM_W = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mips_decode_stage_if.slave bus
);

  // Class index order shared by the class vector and the counter bank.
  localparam int CLS_R   = 0;
  localparam int CLS_I   = 1;
  localparam int CLS_J   = 2;
  localparam int CLS_ILL = 3;
  localparam int NCLS    = 4;

  logic [5:0]        op_next;
  logic [NCLS-1:0]   cls_next;
  logic [IMM_W-1:0]  imm_next;
  logic              in_ready_int;
  logic              accept;

  logic              valid_reg;
  logic [NCLS-1:0]   cls_reg;
  logic [31:0]       instr_reg;
  logic [IMM_W-1:0]  imm_reg;
  logic [NCLS*CNT_W-1:0] cnt_flat;

  assign op_next = bus.instr[31:26];

  // Classify the incoming opcode into exactly one of the four classes.
  always_comb begin
    cls_next = '0;
    case (op_next)
      6'b000000: cls_next[CLS_R] = 1'b1;
      6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b101010,
      6'b001111, 6'b100000, 6'b100011, 6'b101011:
        cls_next[CLS_I] = 1'b1;
      6'b000010, 6'b000011: cls_next[CLS_J] = 1'b1;
      default: cls_next[CLS_ILL] = 1'b1;
    endcase
  end

  // Extend the 16-bit immediate: logical ops zero-extend, lui shifts it up,
  // everything else sign-extends (computed regardless of class).
  always_comb begin
    imm_next = '0;
    case (op_next)
      6'b001100, 6'b001101: imm_next = IMM_W'(bus.instr[15:0]);
      6'b001111:            imm_next = IMM_W'({bus.instr[15:0], 16'h0000});
      default:              imm_next = IMM_W'($signed(bus.instr[15:0]));
    endcase
  end

  // Flush blocks intake so a flushed cycle can never also load or count.
  assign in_ready_int = !bus.flush && (!valid_reg || bus.out_ready);
  assign accept       = bus.in_valid && in_ready_int;

  // Output register: reload on accept, otherwise drain on take or flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      cls_reg   <= '0;
      instr_reg <= '0;
      imm_reg   <= '0;
    end else if (accept) begin
      valid_reg <= 1'b1;
      cls_reg   <= cls_next;
      instr_reg <= bus.instr;
      imm_reg   <= imm_next;
    end else if (bus.flush || bus.out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  // One saturating counter per class, bumped by the class of each accept.
  generate
    for (genvar gi = 0; gi < NCLS; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      // Increment on an accept of this class unless already at full scale.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (accept && cls_next[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = valid_reg;
  assign bus.rtype     = cls_reg[CLS_R];
  assign bus.itype     = cls_reg[CLS_I];
  assign bus.jtype     = cls_reg[CLS_J];
  assign bus.illegal   = cls_reg[CLS_ILL];
  assign bus.opcode    = instr_reg[31:26];
  assign bus.rs        = instr_reg[25:21];
  assign bus.rt        = instr_reg[20:16];
  assign bus.rd        = instr_reg[15:11];
  assign bus.shamt     = instr_reg[10:6];
  assign bus.funct     = instr_reg[5:0];
  assign bus.jidx      = instr_reg[25:0];
  assign bus.imm_ext   = imm_reg;
  assign bus.cnt_r     = cnt_flat[CLS_R*CNT_W +: CNT_W];
  assign bus.cnt_i     = cnt_flat[CLS_I*CNT_W +: CNT_W];
  assign bus.cnt_j     = cnt_flat[CLS_J*CNT_W +: CNT_W];
  assign bus.cnt_ill   = cnt_flat[CLS_ILL*CNT_W +: CNT_W];

endmodule
